// File: rtl/cache_req_arbiter.sv
// Two-port read arbiter in front of a cache lookup port: round-robin grant,
// lookup, optional main-memory fill, LRU update and a one-cycle response.
module cache_req_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_rd,
   input  logic [ADDR_W-1:0] req0_addr,
   output logic              req0_rdy,
   output logic [DATA_W-1:0] req0_data,
   input  logic              req1_rd,
   input  logic [ADDR_W-1:0] req1_addr,
   output logic              req1_rdy,
   output logic [DATA_W-1:0] req1_data,
   output logic              cache_lookup,
   output logic [ADDR_W-1:0] cache_addr,
   input  logic              hit,
   input  logic              miss,
   input  logic [DATA_W-1:0] cache_data,
   output logic              mm_rd,
   input  logic              mm_we,
   input  logic [DATA_W-1:0] mm_data,
   output logic              lru_upd,
   output logic              grant,
   output logic              busy,
   output logic              err
);

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_LOOKUP = 5'b00010,
      S_FILL   = 5'b00100,
      S_UPLRU  = 5'b01000,
      S_RESP   = 5'b10000
   } state_t;

   state_t            state_q;
   logic              grant_q;
   logic              rr_q;
   logic [CNT_W-1:0]  wdog_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] fill_q;
   logic [DATA_W-1:0] data0_q;
   logic [DATA_W-1:0] data1_q;
   logic              rdy0_q;
   logic              rdy1_q;
   logic              lookup_q;
   logic              mm_rd_q;
   logic              lru_q;
   logic              busy_q;
   logic              err_q;

   logic              pick_d;
   logic              wdog_exp_d;

   // rr_q holds the last-served port; on contention the other port wins.
   always_comb begin
      pick_d = 1'b0;
      if (req0_rd && req1_rd) begin
         pick_d = ~rr_q;
      end else if (req1_rd) begin
         pick_d = 1'b1;
      end
      wdog_exp_d = (wdog_q == CNT_W'(TIMEOUT - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         grant_q  <= 1'b0;
         rr_q     <= 1'b0;
         wdog_q   <= '0;
         addr_q   <= '0;
         fill_q   <= '0;
         data0_q  <= '0;
         data1_q  <= '0;
         rdy0_q   <= 1'b0;
         rdy1_q   <= 1'b0;
         lookup_q <= 1'b0;
         mm_rd_q  <= 1'b0;
         lru_q    <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rdy0_q <= 1'b0;
         rdy1_q <= 1'b0;
         lru_q  <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (req0_rd || req1_rd) begin
                  grant_q  <= pick_d;
                  addr_q   <= pick_d ? req1_addr : req0_addr;
                  wdog_q   <= '0;
                  lookup_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  lookup_q <= 1'b0;
                  rr_q     <= grant_q;
                  if (grant_q) begin
                     rdy1_q  <= 1'b1;
                     data1_q <= cache_data;
                  end else begin
                     rdy0_q  <= 1'b1;
                     data0_q <= cache_data;
                  end
                  state_q <= S_RESP;
               end else if (miss) begin
                  lookup_q <= 1'b0;
                  mm_rd_q  <= 1'b1;
                  wdog_q   <= '0;
                  state_q  <= S_FILL;
               end else if (wdog_exp_d) begin
                  lookup_q <= 1'b0;
                  busy_q   <= 1'b0;
                  err_q    <= 1'b1;
                  state_q  <= S_IDLE;
               end else begin
                  wdog_q <= wdog_q + CNT_W'(1);
               end
            end
            S_FILL: begin
               if (mm_we) begin
                  fill_q  <= mm_data;
                  mm_rd_q <= 1'b0;
                  lru_q   <= 1'b1;
                  state_q <= S_UPLRU;
               end else if (wdog_exp_d) begin
                  mm_rd_q <= 1'b0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  wdog_q <= wdog_q + CNT_W'(1);
               end
            end
            S_UPLRU: begin
               rr_q <= grant_q;
               if (grant_q) begin
                  rdy1_q  <= 1'b1;
                  data1_q <= fill_q;
               end else begin
                  rdy0_q  <= 1'b1;
                  data0_q <= fill_q;
               end
               state_q <= S_RESP;
            end
            S_RESP: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               lookup_q <= 1'b0;
               mm_rd_q  <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign req0_rdy     = rdy0_q;
   assign req0_data    = data0_q;
   assign req1_rdy     = rdy1_q;
   assign req1_data    = data1_q;
   assign cache_lookup = lookup_q;
   assign cache_addr   = addr_q;
   assign mm_rd        = mm_rd_q;
   assign lru_upd      = lru_q;
   assign grant        = grant_q;
   assign busy         = busy_q;
   assign err          = err_q;

endmodule
